// File: rtl/axi2umi_pkg.sv
// ----------------------------------------------------------------------------
// axi2umi_pkg
// Constants and types shared by the axi2umi request/response arbiter.
//   - UMI response opcodes (same values as umi_messages.vh)
//   - Bit position of EOM inside a UMI command word
//   - Arbiter FSM state encoding
//   - resp_route(): maps a response opcode to its destination converter
// ----------------------------------------------------------------------------
package axi2umi_pkg;

    localparam logic [4:0] UMI_RESP_READ  = 5'h02;
    localparam logic [4:0] UMI_RESP_WRITE = 5'h04;
    localparam int         UMI_EOM_BIT    = 22;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCK_RD = 2'd1,
        LOCK_WR = 2'd2
    } arb_state_e;

    // Bit 0 selects the read converter, bit 1 the write converter.
    // 2'b00 means the opcode has no owner and the beat is dropped.
    function automatic logic [1:0] resp_route(input logic [4:0] opcode);
        logic [1:0] route;
        case (opcode)
            UMI_RESP_READ:  route = 2'b01;
            UMI_RESP_WRITE: route = 2'b10;
            default:        route = 2'b00;
        endcase
        return route;
    endfunction

endpackage

// File: rtl/axi2umi_outcnt.sv
// ----------------------------------------------------------------------------
// axi2umi_outcnt
// Up/down outstanding-transaction counter with limit compare.
// Saturates at 0 on decrement and at MAXOUT on increment.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   inc, dec      one-cycle increment / decrement strobes
//   count         current count
//   below_limit   count < MAXOUT (requester may start a new transaction)
//   underflow     decrement requested while count is already 0
// ----------------------------------------------------------------------------
module axi2umi_outcnt #(
    parameter int MAXOUT = 4,
    parameter int OCW    = $clog2(MAXOUT + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           inc,
    input  logic           dec,
    output logic [OCW-1:0] count,
    output logic           below_limit,
    output logic           underflow
);

    localparam logic [OCW-1:0] LIMIT = OCW'(MAXOUT);
    localparam logic [OCW-1:0] ZERO  = {OCW{1'b0}};
    localparam logic [OCW-1:0] ONE   = OCW'(1);

    logic [OCW-1:0] count_q;
    logic [OCW-1:0] count_d;

    // Next count: simultaneous inc and dec cancel out.
    always_comb begin
        count_d = count_q;
        if (inc && !dec) begin
            if (count_q != LIMIT) begin
                count_d = count_q + ONE;
            end else begin
                count_d = count_q;
            end
        end else if (dec && !inc) begin
            if (count_q != ZERO) begin
                count_d = count_q - ONE;
            end else begin
                count_d = ZERO;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign count       = count_q;
    assign below_limit = (count_q < LIMIT);
    assign underflow   = dec & ~inc & (count_q == ZERO);

endmodule

// File: rtl/axi2umi_arb.sv
// ----------------------------------------------------------------------------
// axi2umi_arb
// Shares one UMI host port between the AXI read and write converters.
// Requests are arbitrated round-robin per packet; the grant is held until
// the EOM beat. Responses are steered back by opcode.
//
// Optional feature macro: AXI2UMI_ARB_OUTSTANDING_EN
//   defined   - per-requester outstanding counters, MAXOUT limit enforced,
//               responses arriving with a zero count set err_drop
//   undefined - no counters, outstanding outputs tied to 0
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   rd_req_*  / wr_req_*       request packets from read / write converters
//   rd_resp_* / wr_resp_*      response packets to read / write converters
//   uhost_req_*                merged request packet to the UMI host
//   uhost_resp_*               shared response packet from the UMI host
//   rd_outstanding/wr_outstanding  outstanding transaction counts
//   err_drop                   sticky: a response beat was dropped/spurious
// ----------------------------------------------------------------------------
module axi2umi_arb
    import axi2umi_pkg::*;
#(
    parameter int CW     = 32,
    parameter int AW     = 64,
    parameter int DW     = 128,
    parameter int MAXOUT = 4,
    parameter int OCW    = $clog2(MAXOUT + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rd_req_valid,
    output logic           rd_req_ready,
    input  logic [CW-1:0]  rd_req_cmd,
    input  logic [AW-1:0]  rd_req_dstaddr,
    input  logic [AW-1:0]  rd_req_srcaddr,
    input  logic [DW-1:0]  rd_req_data,
    output logic           rd_resp_valid,
    input  logic           rd_resp_ready,
    output logic [CW-1:0]  rd_resp_cmd,
    output logic [AW-1:0]  rd_resp_dstaddr,
    output logic [AW-1:0]  rd_resp_srcaddr,
    output logic [DW-1:0]  rd_resp_data,
    input  logic           wr_req_valid,
    output logic           wr_req_ready,
    input  logic [CW-1:0]  wr_req_cmd,
    input  logic [AW-1:0]  wr_req_dstaddr,
    input  logic [AW-1:0]  wr_req_srcaddr,
    input  logic [DW-1:0]  wr_req_data,
    output logic           wr_resp_valid,
    input  logic           wr_resp_ready,
    output logic [CW-1:0]  wr_resp_cmd,
    output logic [AW-1:0]  wr_resp_dstaddr,
    output logic [AW-1:0]  wr_resp_srcaddr,
    output logic [DW-1:0]  wr_resp_data,
    output logic           uhost_req_valid,
    input  logic           uhost_req_ready,
    output logic [CW-1:0]  uhost_req_cmd,
    output logic [AW-1:0]  uhost_req_dstaddr,
    output logic [AW-1:0]  uhost_req_srcaddr,
    output logic [DW-1:0]  uhost_req_data,
    input  logic           uhost_resp_valid,
    output logic           uhost_resp_ready,
    input  logic [CW-1:0]  uhost_resp_cmd,
    input  logic [AW-1:0]  uhost_resp_dstaddr,
    input  logic [AW-1:0]  uhost_resp_srcaddr,
    input  logic [DW-1:0]  uhost_resp_data,
    output logic [OCW-1:0] rd_outstanding,
    output logic [OCW-1:0] wr_outstanding,
    output logic           err_drop
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       ptr_q;          // 0: read wins a tie, 1: write wins a tie
    logic       ptr_d;
    logic       err_drop_q;
    logic       err_drop_d;

    logic       rd_elig_s;
    logic       wr_elig_s;
    logic       gnt_rd_s;
    logic       gnt_wr_s;
    logic       req_acc_s;
    logic       req_eom_s;
    logic [1:0] route_s;
    logic       resp_acc_s;
    logic       spurious_s;

`ifdef AXI2UMI_ARB_OUTSTANDING_EN
    logic rd_below_s;
    logic wr_below_s;
    logic rd_under_s;
    logic wr_under_s;
    logic rd_inc_s;
    logic wr_inc_s;
    logic rd_dec_s;
    logic wr_dec_s;

    // A transaction counts as issued on its request EOM and retired on its
    // response EOM.
    assign rd_inc_s = req_acc_s & req_eom_s & gnt_rd_s;
    assign wr_inc_s = req_acc_s & req_eom_s & gnt_wr_s;
    assign rd_dec_s = rd_resp_valid & rd_resp_ready & uhost_resp_cmd[UMI_EOM_BIT];
    assign wr_dec_s = wr_resp_valid & wr_resp_ready & uhost_resp_cmd[UMI_EOM_BIT];

    axi2umi_outcnt #(.MAXOUT(MAXOUT), .OCW(OCW)) u_rd_cnt (
        .clk         (clk),
        .reset       (reset),
        .inc         (rd_inc_s),
        .dec         (rd_dec_s),
        .count       (rd_outstanding),
        .below_limit (rd_below_s),
        .underflow   (rd_under_s)
    );

    axi2umi_outcnt #(.MAXOUT(MAXOUT), .OCW(OCW)) u_wr_cnt (
        .clk         (clk),
        .reset       (reset),
        .inc         (wr_inc_s),
        .dec         (wr_dec_s),
        .count       (wr_outstanding),
        .below_limit (wr_below_s),
        .underflow   (wr_under_s)
    );

    assign rd_elig_s  = rd_req_valid & rd_below_s;
    assign wr_elig_s  = wr_req_valid & wr_below_s;
    assign spurious_s = rd_under_s | wr_under_s;
`else
    assign rd_outstanding = {OCW{1'b0}};
    assign wr_outstanding = {OCW{1'b0}};
    assign rd_elig_s      = rd_req_valid;
    assign wr_elig_s      = wr_req_valid;
    assign spurious_s     = 1'b0;
`endif

    // State, round-robin pointer and sticky error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            err_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            err_drop_q <= err_drop_d;
        end
    end

    // Next-state, pointer and error flag.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_acc_s && !req_eom_s) begin
                    state_d = gnt_wr_s ? LOCK_WR : LOCK_RD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCK_RD, LOCK_WR: begin
                if (req_acc_s && req_eom_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // After a completed packet, the other side wins the next tie.
        if (req_acc_s && req_eom_s) begin
            ptr_d = gnt_rd_s;
        end else begin
            ptr_d = ptr_q;
        end

        err_drop_d = err_drop_q | (resp_acc_s & (route_s == 2'b00)) | spurious_s;
    end

    // Grant selection and request-side muxing. Valids never look at a ready.
    always_comb begin
        gnt_rd_s = 1'b0;
        gnt_wr_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_elig_s && wr_elig_s) begin
                    gnt_rd_s = ~ptr_q;
                    gnt_wr_s = ptr_q;
                end else begin
                    gnt_rd_s = rd_elig_s;
                    gnt_wr_s = wr_elig_s;
                end
            end
            LOCK_RD: gnt_rd_s = 1'b1;
            LOCK_WR: gnt_wr_s = 1'b1;
            default: begin
                gnt_rd_s = 1'b0;
                gnt_wr_s = 1'b0;
            end
        endcase

        uhost_req_valid = ~reset & ((gnt_rd_s & rd_req_valid) | (gnt_wr_s & wr_req_valid));
        rd_req_ready    = ~reset & gnt_rd_s & uhost_req_ready;
        wr_req_ready    = ~reset & gnt_wr_s & uhost_req_ready;

        if (gnt_wr_s) begin
            uhost_req_cmd     = wr_req_cmd;
            uhost_req_dstaddr = wr_req_dstaddr;
            uhost_req_srcaddr = wr_req_srcaddr;
            uhost_req_data    = wr_req_data;
        end else begin
            uhost_req_cmd     = rd_req_cmd;
            uhost_req_dstaddr = rd_req_dstaddr;
            uhost_req_srcaddr = rd_req_srcaddr;
            uhost_req_data    = rd_req_data;
        end
    end

    // Response steering by opcode; unowned opcodes are sunk immediately.
    always_comb begin
        route_s       = resp_route(uhost_resp_cmd[4:0]);
        rd_resp_valid = ~reset & uhost_resp_valid & route_s[0];
        wr_resp_valid = ~reset & uhost_resp_valid & route_s[1];
        case (route_s)
            2'b01:   uhost_resp_ready = ~reset & rd_resp_ready;
            2'b10:   uhost_resp_ready = ~reset & wr_resp_ready;
            default: uhost_resp_ready = ~reset;
        endcase
    end

    assign req_acc_s  = uhost_req_valid & uhost_req_ready;
    assign req_eom_s  = uhost_req_cmd[UMI_EOM_BIT];
    assign resp_acc_s = uhost_resp_valid & uhost_resp_ready;

    assign rd_resp_cmd     = uhost_resp_cmd;
    assign rd_resp_dstaddr = uhost_resp_dstaddr;
    assign rd_resp_srcaddr = uhost_resp_srcaddr;
    assign rd_resp_data    = uhost_resp_data;
    assign wr_resp_cmd     = uhost_resp_cmd;
    assign wr_resp_dstaddr = uhost_resp_dstaddr;
    assign wr_resp_srcaddr = uhost_resp_srcaddr;
    assign wr_resp_data    = uhost_resp_data;

    assign err_drop = err_drop_q;

endmodule

// File: tb/tb_axi2umi_arb.sv
// ----------------------------------------------------------------------------
// tb_axi2umi_arb
// Self-checking bench for axi2umi_arb (MAXOUT=2). Directed scenarios followed
// by random traffic, all compared against a packet-level reference model.
// ----------------------------------------------------------------------------
module tb_axi2umi_arb;

    localparam int CW = 32;
    localparam int AW = 64;
    localparam int DW = 128;
    localparam int MAXOUT = 2;
    localparam int OCW = $clog2(MAXOUT + 1);
`ifdef AXI2UMI_ARB_OUTSTANDING_EN
    localparam bit OUT_EN = 1'b1;
`else
    localparam bit OUT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic rd_req_valid, rd_req_ready, wr_req_valid, wr_req_ready;
    logic [CW-1:0] rd_req_cmd, wr_req_cmd;
    logic [AW-1:0] rd_req_dstaddr, rd_req_srcaddr, wr_req_dstaddr, wr_req_srcaddr;
    logic [DW-1:0] rd_req_data, wr_req_data;
    logic rd_resp_valid, rd_resp_ready, wr_resp_valid, wr_resp_ready;
    logic [CW-1:0] rd_resp_cmd, wr_resp_cmd;
    logic [AW-1:0] rd_resp_dstaddr, rd_resp_srcaddr, wr_resp_dstaddr, wr_resp_srcaddr;
    logic [DW-1:0] rd_resp_data, wr_resp_data;
    logic uhost_req_valid, uhost_req_ready;
    logic [CW-1:0] uhost_req_cmd;
    logic [AW-1:0] uhost_req_dstaddr, uhost_req_srcaddr;
    logic [DW-1:0] uhost_req_data;
    logic uhost_resp_valid, uhost_resp_ready;
    logic [CW-1:0] uhost_resp_cmd;
    logic [AW-1:0] uhost_resp_dstaddr, uhost_resp_srcaddr;
    logic [DW-1:0] uhost_resp_data;
    logic [OCW-1:0] rd_outstanding, wr_outstanding;
    logic err_drop;

    axi2umi_arb #(.CW(CW), .AW(AW), .DW(DW), .MAXOUT(MAXOUT)) dut (
        .clk(clk), .reset(reset),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_cmd(rd_req_cmd), .rd_req_dstaddr(rd_req_dstaddr),
        .rd_req_srcaddr(rd_req_srcaddr), .rd_req_data(rd_req_data),
        .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
        .rd_resp_cmd(rd_resp_cmd), .rd_resp_dstaddr(rd_resp_dstaddr),
        .rd_resp_srcaddr(rd_resp_srcaddr), .rd_resp_data(rd_resp_data),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_req_cmd(wr_req_cmd), .wr_req_dstaddr(wr_req_dstaddr),
        .wr_req_srcaddr(wr_req_srcaddr), .wr_req_data(wr_req_data),
        .wr_resp_valid(wr_resp_valid), .wr_resp_ready(wr_resp_ready),
        .wr_resp_cmd(wr_resp_cmd), .wr_resp_dstaddr(wr_resp_dstaddr),
        .wr_resp_srcaddr(wr_resp_srcaddr), .wr_resp_data(wr_resp_data),
        .uhost_req_valid(uhost_req_valid), .uhost_req_ready(uhost_req_ready),
        .uhost_req_cmd(uhost_req_cmd), .uhost_req_dstaddr(uhost_req_dstaddr),
        .uhost_req_srcaddr(uhost_req_srcaddr), .uhost_req_data(uhost_req_data),
        .uhost_resp_valid(uhost_resp_valid), .uhost_resp_ready(uhost_resp_ready),
        .uhost_resp_cmd(uhost_resp_cmd), .uhost_resp_dstaddr(uhost_resp_dstaddr),
        .uhost_resp_srcaddr(uhost_resp_srcaddr), .uhost_resp_data(uhost_resp_data),
        .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
        .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: which side owns an unfinished packet (-1 none),
    // which side wins the next tie, outstanding counts and sticky error.
    int m_lock;
    int m_prio;
    int m_cnt [2];
    bit m_err;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] mk_cmd(input logic [4:0] op, input bit eom);
        logic [CW-1:0] c;
        c = CW'($urandom());
        c[4:0] = op;
        c[22] = eom;
        return c;
    endfunction

    task automatic idle_inputs();
        rd_req_valid = 1'b0; wr_req_valid = 1'b0;
        rd_req_cmd = mk_cmd(5'h01, 1'b1); wr_req_cmd = mk_cmd(5'h03, 1'b1);
        rd_req_dstaddr = {$urandom(), $urandom()}; rd_req_srcaddr = {$urandom(), $urandom()};
        wr_req_dstaddr = {$urandom(), $urandom()}; wr_req_srcaddr = {$urandom(), $urandom()};
        rd_req_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        wr_req_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        uhost_req_ready = 1'b1;
        uhost_resp_valid = 1'b0; uhost_resp_cmd = mk_cmd(5'h02, 1'b1);
        uhost_resp_dstaddr = {$urandom(), $urandom()}; uhost_resp_srcaddr = {$urandom(), $urandom()};
        uhost_resp_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        rd_resp_ready = 1'b1; wr_resp_ready = 1'b1;
    endtask

    // Check all outputs for the current inputs against the model, then
    // advance the model and the clock by one cycle.
    task automatic step();
        bit vld [2];
        bit elig [2];
        bit inc [2];
        bit dec [2];
        int g, side;
        bit exp_uv, acc, eom, exp_urr, racc;
        logic [CW-1:0] gcmd;
        logic [DW-1:0] gdata;
        #2;
        check_eq("rd_out", rd_outstanding, OCW'(m_cnt[0]));
        check_eq("wr_out", wr_outstanding, OCW'(m_cnt[1]));
        check_eq("err_drop", err_drop, m_err);
        check_eq("rd_resp_data", rd_resp_data, uhost_resp_data);
        check_eq("wr_resp_cmd", wr_resp_cmd, uhost_resp_cmd);
        if (reset) begin
            check_eq("rst_uhost_req_valid", uhost_req_valid, 1'b0);
            check_eq("rst_rd_req_ready", rd_req_ready, 1'b0);
            check_eq("rst_wr_req_ready", wr_req_ready, 1'b0);
            check_eq("rst_rd_resp_valid", rd_resp_valid, 1'b0);
            check_eq("rst_wr_resp_valid", wr_resp_valid, 1'b0);
            check_eq("rst_uhost_resp_ready", uhost_resp_ready, 1'b0);
            m_lock = -1; m_prio = 0; m_cnt[0] = 0; m_cnt[1] = 0; m_err = 1'b0;
        end else begin
            vld[0] = rd_req_valid; vld[1] = wr_req_valid;
            for (int s = 0; s < 2; s++) begin
                elig[s] = vld[s] && (!OUT_EN || m_cnt[s] < MAXOUT);
                inc[s] = 1'b0; dec[s] = 1'b0;
            end
            if (m_lock >= 0) g = m_lock;
            else if (elig[0] && elig[1]) g = m_prio;
            else if (elig[0]) g = 0;
            else if (elig[1]) g = 1;
            else g = -1;
            exp_uv = (g == 0 && vld[0]) || (g == 1 && vld[1]);
            check_eq("uhost_req_valid", uhost_req_valid, exp_uv);
            check_eq("rd_req_ready", rd_req_ready, g == 0 && uhost_req_ready);
            check_eq("wr_req_ready", wr_req_ready, g == 1 && uhost_req_ready);
            gcmd  = (g == 1) ? wr_req_cmd : rd_req_cmd;
            gdata = (g == 1) ? wr_req_data : rd_req_data;
            if (exp_uv) begin
                check_eq("uhost_req_cmd", uhost_req_cmd, gcmd);
                check_eq("uhost_req_data", uhost_req_data, gdata);
            end
            acc = exp_uv && uhost_req_ready;
            eom = gcmd[22];
            if (acc) begin
                if (eom) begin
                    m_lock = -1;
                    m_prio = 1 - g;
                    inc[g] = OUT_EN;
                end else begin
                    m_lock = g;
                end
            end

            case (uhost_resp_cmd[4:0])
                5'h02:   side = 0;
                5'h04:   side = 1;
                default: side = -1;
            endcase
            exp_urr = (side == 0) ? rd_resp_ready : (side == 1) ? wr_resp_ready : 1'b1;
            check_eq("rd_resp_valid", rd_resp_valid, uhost_resp_valid && side == 0);
            check_eq("wr_resp_valid", wr_resp_valid, uhost_resp_valid && side == 1);
            check_eq("uhost_resp_ready", uhost_resp_ready, exp_urr);
            racc = uhost_resp_valid && exp_urr;
            if (racc && side < 0) m_err = 1'b1;
            if (racc && side >= 0 && uhost_resp_cmd[22]) dec[side] = OUT_EN;
            for (int s = 0; s < 2; s++) begin
                if (inc[s] && !dec[s]) m_cnt[s] = m_cnt[s] + 1;
                else if (dec[s] && !inc[s]) begin
                    if (m_cnt[s] == 0) m_err = 1'b1;
                    else m_cnt[s] = m_cnt[s] - 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    logic [DW-1:0] held;

    initial begin
        m_lock = -1; m_prio = 0; m_cnt[0] = 0; m_cnt[1] = 0; m_err = 1'b0;
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        do_reset();
        check_eq("reset_rd_out", rd_outstanding, OCW'(0));
        check_eq("reset_err", err_drop, 1'b0);

        // Alternating single-beat grants, read first.
        rd_req_valid = 1'b1; wr_req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_req_cmd = mk_cmd(5'h01, 1'b1); wr_req_cmd = mk_cmd(5'h03, 1'b1);
            #1;
            check_eq("alt_rd_gnt", rd_req_ready, (i % 2) == 0);
            check_eq("alt_wr_gnt", wr_req_ready, (i % 2) == 1);
            step();
        end

        // Write 3-beat packet holds off read.
        do_reset();
        rd_req_valid = 1'b1; rd_req_cmd = mk_cmd(5'h01, 1'b1);
        step();
        wr_req_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            wr_req_cmd = mk_cmd(5'h03, b == 2);
            #1;
            check_eq("lock_rd_blocked", rd_req_ready, 1'b0);
            check_eq("lock_wr_gnt", wr_req_ready, 1'b1);
            step();
        end
        wr_req_cmd = mk_cmd(5'h03, 1'b1);
        #1;
        check_eq("after_lock_rd_gnt", rd_req_ready, 1'b1);
        step();

`ifdef AXI2UMI_ARB_OUTSTANDING_EN
        // Outstanding limit stalls the third read until a response retires one.
        do_reset();
        rd_req_valid = 1'b1; rd_req_cmd = mk_cmd(5'h01, 1'b1);
        step();
        step();
        #1;
        check_eq("limit_stall", rd_req_ready, 1'b0);
        check_eq("limit_cnt", rd_outstanding, OCW'(2));
        step();
        uhost_resp_valid = 1'b1; uhost_resp_cmd = mk_cmd(5'h02, 1'b1);
        step();
        uhost_resp_valid = 1'b0;
        #1;
        check_eq("limit_release", rd_req_ready, 1'b1);
        check_eq("limit_cnt_dec", rd_outstanding, OCW'(1));
        step();
`endif

        // Response routing by opcode.
        do_reset();
        uhost_resp_valid = 1'b1;
        uhost_resp_cmd = mk_cmd(5'h02, 1'b0);
        #1;
        check_eq("route_rd", rd_resp_valid, 1'b1);
        step();
        uhost_resp_cmd = mk_cmd(5'h04, 1'b0);
        #1;
        check_eq("route_wr", wr_resp_valid, 1'b1);
        step();
        uhost_resp_cmd = mk_cmd(5'h07, 1'b1);
        rd_resp_ready = 1'b0; wr_resp_ready = 1'b0;
        #1;
        check_eq("drop_ready", uhost_resp_ready, 1'b1);
        step();
        uhost_resp_valid = 1'b0;
        #1;
        check_eq("drop_err", err_drop, 1'b1);
        step();

        // Back-pressure on the read response.
        do_reset();
        uhost_resp_valid = 1'b1; uhost_resp_cmd = mk_cmd(5'h02, 1'b0);
        rd_resp_ready = 1'b0;
        held = uhost_resp_data;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("bp_ready", uhost_resp_ready, 1'b0);
            check_eq("bp_data", rd_resp_data, held);
            step();
        end
        rd_resp_ready = 1'b1;
        #1;
        check_eq("bp_release", uhost_resp_ready, 1'b1);
        step();
        uhost_resp_valid = 1'b0;

        // Reset in the middle of a locked write packet.
        do_reset();
        rd_req_valid = 1'b1; rd_req_cmd = mk_cmd(5'h01, 1'b1);
        step();
        rd_req_valid = 1'b0; wr_req_valid = 1'b1; wr_req_cmd = mk_cmd(5'h03, 1'b1);
        step();
        wr_req_cmd = mk_cmd(5'h03, 1'b0);
        step();
        #1;
        check_eq("mid_cnt_rd", rd_outstanding, OUT_EN ? OCW'(1) : OCW'(0));
        check_eq("mid_cnt_wr", wr_outstanding, OUT_EN ? OCW'(1) : OCW'(0));
        reset = 1'b1; rd_req_valid = 1'b1;
        #1;
        check_eq("mid_rst_valid", uhost_req_valid, 1'b0);
        step();
        reset = 1'b0;
        rd_req_cmd = mk_cmd(5'h01, 1'b1); wr_req_cmd = mk_cmd(5'h03, 1'b1);
        #1;
        check_eq("post_rst_rd_gnt", rd_req_ready, 1'b1);
        check_eq("post_rst_wr_gnt", wr_req_ready, 1'b0);
        check_eq("post_rst_cnt", wr_outstanding, OCW'(0));
        step();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            rd_req_valid = ($urandom_range(0, 3) != 0);
            wr_req_valid = ($urandom_range(0, 3) != 0);
            rd_req_cmd = mk_cmd(5'h01, $urandom_range(0, 1) == 1);
            wr_req_cmd = mk_cmd(5'h03, $urandom_range(0, 1) == 1);
            rd_req_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            wr_req_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            uhost_req_ready = ($urandom_range(0, 3) != 0);
            uhost_resp_valid = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0, 1:    uhost_resp_cmd = mk_cmd(5'h02, $urandom_range(0, 1) == 1);
                2, 3:    uhost_resp_cmd = mk_cmd(5'h04, $urandom_range(0, 1) == 1);
                4:       uhost_resp_cmd = mk_cmd(5'h07, 1'b1);
                default: uhost_resp_cmd = mk_cmd(5'h00, 1'b0);
            endcase
            uhost_resp_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            rd_resp_ready = ($urandom_range(0, 3) != 0);
            wr_resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
